// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared fetch/decode bus width and exception codes
package if_fetch_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 103;

    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_TLBL = 5'h02;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // a push into a full FIFO is legal only when the head leaves in the same cycle
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch stage with outstanding icache reads, instruction queue and redirect
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic                       ws_cancel,
    input  logic [31:0]                new_pc,
    input  logic                       br_redirect,
    input  logic [31:0]                br_target,
    output logic                       icache_valid,
    output logic                       icache_op,
    output logic [7:0]                 icache_index,
    output logic [19:0]                icache_tlb_tag,
    output logic [3:0]                 icache_offset,
    output logic [3:0]                 icache_wstrb,
    output logic [31:0]                icache_wdata,
    input  logic                       icache_addrok,
    input  logic                       icache_dataok,
    input  logic [31:0]                icache_rdata,
    output logic [18:0]                s0_vpn2,
    output logic                       s0_odd_page,
    output logic [7:0]                 s0_asid,
    input  logic                       s0_found,
    input  logic                       s0_v,
    input  logic [19:0]                s0_pfn,
    input  logic [7:0]                 entryhi_asid
);

    localparam int QCW = $clog2(QDEPTH + 1);
    localparam int OCW = $clog2(MAX_OUT + 1);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0] inflight_q, inflight_d;
    logic [OCW-1:0] drop_q, drop_d;
    logic         halt_q, halt_d;

    logic         unmapped, adel, tlb_miss, tlb_inv, fetch_ex, ex_refill;
    logic [4:0]   ex_code;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  occupancy;
    logic         req_fire, ex_push, resp_keep;
    logic         q_push, q_pop, q_full, q_empty;
    logic [FS_TO_DS_BUS_WD-1:0] q_push_data;
    logic [QCW-1:0] q_count;
    logic [31:0]  tag_pc;
    logic [OCW-1:0] tag_count;
    logic         tag_full, tag_empty;
    logic         unused_tag_status;

    assign unused_tag_status = ^{tag_count, tag_full, tag_empty};

    assign icache_op      = 1'b0;
    assign icache_wstrb   = 4'h0;
    assign icache_wdata   = 32'h0;
    assign icache_index   = fetch_pc_q[11:4];
    assign icache_offset  = fetch_pc_q[3:0];
    assign icache_tlb_tag = unmapped ? fetch_pc_q[31:12] : s0_pfn;
    assign s0_vpn2        = fetch_pc_q[31:13];
    assign s0_odd_page    = fetch_pc_q[12];
    assign s0_asid        = entryhi_asid;
    assign fs_to_ds_valid = ~q_empty;

    always_comb begin
        unmapped    = (fetch_pc_q[31:30] == 2'b10);
        adel        = |fetch_pc_q[1:0];
        tlb_miss    = ~unmapped & ~s0_found;
        tlb_inv     = ~unmapped & s0_found & ~s0_v;
        fetch_ex    = adel | tlb_miss | tlb_inv;
        ex_code     = adel ? EX_ADEL : EX_TLBL;
        ex_refill   = ~adel & tlb_miss;
        redirect    = ws_cancel | br_redirect;
        redirect_pc = ws_cancel ? new_pc : br_target;
        occupancy   = 32'(q_count) + 32'(inflight_q);

        // every issued read reserves a queue slot so a returning word always fits
        icache_valid = resetn & ~halt_q & ~fetch_ex & ~redirect
                     & (32'(inflight_q) < 32'(MAX_OUT))
                     & (occupancy < 32'(QDEPTH));
        req_fire  = icache_valid & icache_addrok;
        ex_push   = ~halt_q & fetch_ex & ~redirect & (inflight_q == '0)
                  & (drop_q == '0) & ~q_full;
        resp_keep = icache_dataok & (drop_q == '0) & ~redirect;
        q_push    = resp_keep | ex_push;
        q_pop     = ~q_empty & ds_allowin & ~redirect;

        q_push_data = {2'b00, 5'h00, 32'h0, icache_rdata, tag_pc};
        if (ex_push) q_push_data = {ex_refill, 1'b1, ex_code, fetch_pc_q, 32'h0, fetch_pc_q};

        inflight_d = inflight_q + OCW'(req_fire) - OCW'(icache_dataok);

        drop_d = drop_q;
        if (redirect) begin
            drop_d = inflight_d;
        end else if (icache_dataok && drop_q != '0) begin
            drop_d = drop_q - 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        halt_d = halt_q;
        if (redirect) begin
            halt_d = 1'b0;
        end else if (ex_push) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            halt_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halt_q     <= halt_d;
        end
    end

    sync_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (QDEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .resetn    (resetn),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect),
        .pop_data  (fs_to_ds_bus),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // tags follow the icache's in-order return and survive redirects so stale words still pop their tag
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (icache_dataok),
        .flush     (1'b0),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed bench for if_fetch_queue with an in-order icache responder
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam logic [31:0] KEY = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        resetn, ds_allowin, ws_cancel, br_redirect;
    logic [31:0] new_pc, br_target;
    logic        fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic        icache_valid, icache_op;
    logic [7:0]  icache_index;
    logic [19:0] icache_tlb_tag;
    logic [3:0]  icache_offset, icache_wstrb;
    logic [31:0] icache_wdata;
    logic        icache_addrok, icache_dataok;
    logic [31:0] icache_rdata;
    logic [18:0] s0_vpn2;
    logic        s0_odd_page;
    logic [7:0]  s0_asid;
    logic        s0_found, s0_v;
    logic [19:0] s0_pfn;
    logic [7:0]  entryhi_asid;

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc = 0;
    logic        resp_en;
    logic        v_seen;
    logic [31:0] pend_addr[$];
    int          pend_rdy[$];
    logic [FS_TO_DS_BUS_WD-1:0] got[$];

    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ws_cancel(ws_cancel), .new_pc(new_pc),
        .br_redirect(br_redirect), .br_target(br_target),
        .icache_valid(icache_valid), .icache_op(icache_op),
        .icache_index(icache_index), .icache_tlb_tag(icache_tlb_tag),
        .icache_offset(icache_offset), .icache_wstrb(icache_wstrb),
        .icache_wdata(icache_wdata), .icache_addrok(icache_addrok),
        .icache_dataok(icache_dataok), .icache_rdata(icache_rdata),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_v(s0_v), .s0_pfn(s0_pfn),
        .entryhi_asid(entryhi_asid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive dataok, observe handshakes, advance the responder model
    task automatic step();
        logic        acc;
        logic [31:0] acc_addr;
        icache_dataok = 1'b0;
        icache_rdata  = 32'h0;
        if (resetn && resp_en && pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
            icache_dataok = 1'b1;
            icache_rdata  = pend_addr[0] ^ KEY;
        end
        #1;
        v_seen   = icache_valid;
        acc      = icache_valid & icache_addrok;
        acc_addr = {icache_tlb_tag, icache_index, icache_offset};
        if (fs_to_ds_valid && ds_allowin && !ws_cancel && !br_redirect) got.push_back(fs_to_ds_bus);
        @(posedge clk);
        if (icache_dataok) begin
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end
        if (acc) begin
            pend_addr.push_back(acc_addr);
            pend_rdy.push_back(cyc + 2);
            n_acc++;
        end
        if (!resetn) begin
            pend_addr.delete();
            pend_rdy.delete();
        end
        cyc++;
        @(negedge clk);
        icache_dataok = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ws_cancel = 1'b0;
        br_redirect = 1'b0;
        step();
        step();
        resetn = 1'b1;
        got.delete();
        n_acc = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        resetn = 1'b0; ds_allowin = 1'b1; ws_cancel = 1'b0; br_redirect = 1'b0;
        new_pc = 32'h0; br_target = 32'h0; icache_addrok = 1'b1;
        icache_dataok = 1'b0; icache_rdata = 32'h0; resp_en = 1'b1;
        s0_found = 1'b1; s0_v = 1'b1; s0_pfn = 20'h0; entryhi_asid = 8'h3c;
        @(negedge clk);

        // reset state
        step();
        step();
        #1;
        check("rst_fs_valid", fs_to_ds_valid, 1'b0);
        check("rst_icache_valid", icache_valid, 1'b0);
        resetn = 1'b1;
        #1;
        check("rst_first_req", icache_valid, 1'b1);
        check("rst_tag", icache_tlb_tag, 20'hbfc00);
        check("rst_index_offset", {icache_index, icache_offset}, 12'h000);
        check("rst_fs_valid_after", fs_to_ds_valid, 1'b0);

        // 1: streaming fetch, in-order delivery
        got.delete();
        steps(24);
        check("stream_count_ge6", got.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) begin
                check("stream_pc", got[i][31:0], 32'hbfc00000 + 32'(4 * i));
                check("stream_inst", got[i][63:32], (32'hbfc00000 + 32'(4 * i)) ^ KEY);
                check("stream_ex", got[i][101], 1'b0);
            end
        end

        // 2: ID stalled, queue fills with exactly QDEPTH reservations
        ds_allowin = 1'b0;
        do_reset();
        steps(20);
        check("full_req_count", n_acc, 4);
        #1;
        check("full_icache_valid", icache_valid, 1'b0);
        check("full_fs_valid", fs_to_ds_valid, 1'b1);
        check("full_head_pc", fs_to_ds_bus[31:0], 32'hbfc00000);
        check("full_head_inst", fs_to_ds_bus[63:32], 32'hbfc00000 ^ KEY);
        ds_allowin = 1'b1;
        steps(4);
        check("drain_order", {got[0][31:0], got[3][31:0]}, {32'hbfc00000, 32'hbfc0000c});

        // 3: ws_cancel with two in flight
        ds_allowin = 1'b0;
        resp_en = 1'b0;
        do_reset();
        steps(3);
        check("cancel_inflight", n_acc, 2);
        ws_cancel = 1'b1;
        new_pc = 32'hbfc00380;
        step();
        check("cancel_no_req", v_seen, 1'b0);
        ws_cancel = 1'b0;
        resp_en = 1'b1;
        ds_allowin = 1'b1;
        steps(10);
        check("cancel_got", got.size() > 0, 1'b1);
        if (got.size() > 0) begin
            check("cancel_first_pc", got[0][31:0], 32'hbfc00380);
            check("cancel_first_inst", got[0][63:32], 32'hbfc00380 ^ KEY);
        end

        // 4: br_redirect coincides with a dataok, one more in flight
        resp_en = 1'b0;
        do_reset();
        steps(3);
        br_redirect = 1'b1;
        br_target = 32'hbfc01000;
        resp_en = 1'b1;
        step();
        br_redirect = 1'b0;
        #1;
        check("br_no_entry", fs_to_ds_valid, 1'b0);
        step();
        #1;
        check("br_stale_dropped", fs_to_ds_valid, 1'b0);
        steps(10);
        check("br_got", got.size() > 0, 1'b1);
        if (got.size() > 0) check("br_first_pc", got[0][31:0], 32'hbfc01000);

        // 5: misaligned target raises AdEL and halts
        do_reset();
        ws_cancel = 1'b1;
        new_pc = 32'hbfc00382;
        step();
        ws_cancel = 1'b0;
        n_acc = 0;
        steps(8);
        check("adel_no_req", n_acc, 0);
        check("adel_one_entry", got.size(), 1);
        if (got.size() > 0)
            check("adel_bus", got[0], {1'b0, 1'b1, 5'h04, 32'hbfc00382, 32'h0, 32'hbfc00382});
        #1;
        check("adel_halt_icache", icache_valid, 1'b0);
        check("adel_halt_fs", fs_to_ds_valid, 1'b0);
        ws_cancel = 1'b1;
        new_pc = 32'hbfc00000;
        step();
        ws_cancel = 1'b0;
        #1;
        check("adel_resume", icache_valid, 1'b1);

        // 6: mapped fetch with TLB refill, then invalid entry
        resp_en = 1'b0;
        do_reset();
        s0_found = 1'b0;
        ws_cancel = 1'b1;
        new_pc = 32'h00400000;
        step();
        ws_cancel = 1'b0;
        steps(6);
        check("refill_one_entry", got.size(), 1);
        if (got.size() > 0)
            check("refill_bus", got[0], {1'b1, 1'b1, 5'h02, 32'h00400000, 32'h0, 32'h00400000});
        got.delete();
        s0_found = 1'b1;
        s0_v = 1'b0;
        ws_cancel = 1'b1;
        step();
        ws_cancel = 1'b0;
        steps(6);
        check("inv_one_entry", got.size(), 1);
        if (got.size() > 0)
            check("inv_bus", got[0], {1'b0, 1'b1, 5'h02, 32'h00400000, 32'h0, 32'h00400000});
        s0_v = 1'b1;
        s0_pfn = 20'h12345;
        ws_cancel = 1'b1;
        step();
        ws_cancel = 1'b0;
        #1;
        check("mapped_req", icache_valid, 1'b1);
        check("mapped_tag", icache_tlb_tag, 20'h12345);
        check("mapped_vpn2", s0_vpn2, 19'h00200);
        check("mapped_odd_asid", {s0_odd_page, s0_asid}, 9'h03c);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
